// File: rtl/ws_pkg.sv
// Shared types and constants for the WS2812b/WS2811 frame scheduler.
package ws_pkg;

  localparam int MAX_STRIPS   = 8;
  localparam int DEF_LEDS_W   = 9;
  localparam int DEF_PERIOD_W = 24;
  localparam int GUARD_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    LATCH     = 3'd2,
    ISSUE     = 3'd3,
    GUARD     = 3'd4,
    WAIT_DONE = 3'd5
  } sched_state_t;

endpackage

// File: rtl/ws_frame_timer.sv
// Frame-rate period counter: one-cycle tick every max(period,1) cycles while enabled.
module ws_frame_timer
  import ws_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] per_eff;

  assign per_eff = (period_i == '0) ? PERIOD_W'(1) : period_i;
  assign tick_o  = en_i && (cnt_q == per_q - PERIOD_W'(1));

  // The active period is only reloaded at a wrap (or while idle), so a
  // mid-count change never lets the counter run past its compare value.
  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
      per_d = per_eff;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      per_q <= per_eff;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/ws_frame_sched.sv
// Frame scheduler: ticks frames, staggers per-strip start pulses, ping-pong bank swap.
module ws_frame_sched
  import ws_pkg::*;
#(
  parameter int NUM_STRIPS = MAX_STRIPS,
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int LEDS_W     = DEF_LEDS_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_STRIPS-1:0] strip_mask,
  input  logic [LEDS_W-1:0]     leds_cfg,
  input  logic [PERIOD_W-1:0]   frame_period,
  input  logic                  swap_req,
  input  logic [NUM_STRIPS-1:0] busy,
  output logic [NUM_STRIPS-1:0] start,
  output logic                  bank,
  output logic [LEDS_W-1:0]     leds,
  output logic                  swap_ack,
  output logic                  frame_overrun,
  output logic [15:0]           frame_cnt,
  output logic [2:0]            dbg_state
);

  localparam int IDX_W = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STRIPS - 1);

  sched_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            guard_q, guard_d;
  logic [NUM_STRIPS-1:0] mask_q, mask_d;
  logic [LEDS_W-1:0]     leds_q, leds_d;
  logic                  bank_q, bank_d;
  logic                  pending_q, pending_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  tick;

  ws_frame_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en),
    .period_i (frame_period),
    .tick_o   (tick)
  );

  // start[i] is a single-cycle request; the driver answers with busy[i]
  // within two cycles and holds it until the strip transfer is finished.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    guard_d     = guard_q;
    mask_d      = mask_q;
    leds_d      = leds_q;
    bank_d      = bank_q;
    frame_cnt_d = frame_cnt_q;
    start       = '0;
    swap_ack    = 1'b0;
    unique case (state_q)
      IDLE: if (en) state_d = WAIT_TICK;
      WAIT_TICK: begin
        if (tick)     state_d = LATCH;
        else if (!en) state_d = IDLE;
      end
      LATCH: begin
        mask_d      = strip_mask;
        leds_d      = leds_cfg;
        frame_cnt_d = frame_cnt_q + 16'd1;
        idx_d       = '0;
        if (pending_q) begin
          bank_d   = ~bank_q;
          swap_ack = 1'b1;
        end
        state_d = (strip_mask == '0) ? WAIT_TICK : ISSUE;
      end
      ISSUE: begin
        start[idx_q] = mask_q[idx_q];
        if (idx_q == LAST_IDX) begin
          state_d = GUARD;
          guard_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      GUARD: begin
        if (guard_q == 2'(GUARD_CYCLES - 1)) state_d = WAIT_DONE;
        else                                  guard_d = guard_q + 2'd1;
      end
      WAIT_DONE: begin
        if ((busy & mask_q) == '0) state_d = en ? WAIT_TICK : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A request arriving during LATCH survives the clear and waits a frame.
    pending_d     = (swap_ack ? 1'b0 : pending_q) | swap_req;
    frame_overrun = tick && (state_q != IDLE) && (state_q != WAIT_TICK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      guard_q     <= '0;
      mask_q      <= '0;
      leds_q      <= '0;
      bank_q      <= 1'b0;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      guard_q     <= guard_d;
      mask_q      <= mask_d;
      leds_q      <= leds_d;
      bank_q      <= bank_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bank      = bank_q;
  assign leds      = leds_q;
  assign frame_cnt = frame_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ws_frame_sched.sv
// Bench for ws_frame_sched: table-driven frame runs plus corner-case sequences.
module tb_ws_frame_sched;
  import ws_pkg::*;

  localparam int NS = 8;
  localparam int PW = 24;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          swap_req = 1'b0;
  logic [NS-1:0] strip_mask = '0;
  logic [NS-1:0] busy = '0;
  logic [NS-1:0] start;
  logic [LW-1:0] leds_cfg = '0;
  logic [LW-1:0] leds;
  logic [PW-1:0] frame_period = '0;
  logic          bank, swap_ack, frame_overrun;
  logic [15:0]   frame_cnt;
  logic [2:0]    dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int busy_len = 0;
  int bcnt[NS];

  logic [31:0] exp_q[$];  // {cycle[23:0], start vector}
  logic [31:0] ack_q[$];  // cycles with a swap_ack pulse
  logic [31:0] ovr_q[$];  // cycles with a frame_overrun pulse

  typedef struct {
    logic [PW-1:0] period;
    logic [NS-1:0] mask;
    logic [LW-1:0] leds;
    int            blen;
    int            nframes;
    int            spacing;
    logic [LW-1:0] exp_leds;
  } row_t;
  row_t rows[4];

  ws_frame_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en), .strip_mask(strip_mask),
    .leds_cfg(leds_cfg), .frame_period(frame_period), .swap_req(swap_req),
    .busy(busy), .start(start), .bank(bank), .leds(leds),
    .swap_ack(swap_ack), .frame_overrun(frame_overrun),
    .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #25 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic evt_fail(input string name, input int c);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: unexpected pulse at cycle %0d, none required", name, c);
  endtask

  // Monitor + busy model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    if (start != '0) begin
      act = {cyc[23:0], start};
      if (exp_q.size() == 0) evt_fail("start", cyc);
      else                   chk("start", act, exp_q.pop_front());
    end
    if (swap_ack) begin
      if (ack_q.size() == 0) evt_fail("swap_ack", cyc);
      else                   chk("swap_ack_cycle", cyc, ack_q.pop_front());
    end
    if (frame_overrun) begin
      if (ovr_q.size() == 0) evt_fail("frame_overrun", cyc);
      else                   chk("overrun_cycle", cyc, ovr_q.pop_front());
    end
    for (int i = 0; i < NS; i++) begin
      if (start[i])         bcnt[i] = busy_len;
      else if (bcnt[i] > 0) bcnt[i] = bcnt[i] - 1;
      busy[i] = (bcnt[i] != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_at(input int c);
    wait_cyc(c);
    @(negedge clk);
  endtask

  task automatic pulse_swap(input int c);
    wait_cyc(c);
    swap_req = 1'b1;
    wait_cyc(c + 1);
    swap_req = 1'b0;
  endtask

  task automatic push_frame(input int tick, input logic [NS-1:0] m);
    logic [7:0] b;
    for (int i = 0; i < NS; i++) begin
      b = 8'd1 << i;
      if (m[i]) exp_q.push_back({24'(tick + 2 + i), b});
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    swap_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_bank", bank, 0);
    chk("rst_leds", leds, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_overrun", frame_overrun, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (dbg_state != IDLE && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idle", dbg_state, IDLE);
  endtask

  task automatic chk_queues();
    chk("start_left", exp_q.size(), 0);
    chk("ack_left", ack_q.size(), 0);
    chk("ovr_left", ovr_q.size(), 0);
  endtask

  task automatic setup(input logic [PW-1:0] p, input logic [NS-1:0] m,
                       input logic [LW-1:0] l, input int bl);
    frame_period = p;
    strip_mask   = m;
    leds_cfg     = l;
    busy_len     = bl;
    wait_cyc(cyc + 2);
  endtask

  // ---------------- test ----------------
  initial begin
    int t0, t1, last;
    for (int i = 0; i < NS; i++) bcnt[i] = 0;
    rows[0] = '{24'd100, 8'h05, 9'd300, 50, 3, 100, 9'd300};
    rows[1] = '{24'd10,  8'h00, 9'd7,   0,  4, 10,  9'd7};
    rows[2] = '{24'd64,  8'h81, 9'd511, 20, 2, 64,  9'd511};
    rows[3] = '{24'd30,  8'h5A, 9'd1,   5,  3, 30,  9'd1};

    // Steady-state frames from the table: start timing, counts, leds, bank.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      setup(rows[r].period, rows[r].mask, rows[r].leds, rows[r].blen);
      t0 = cyc;
      en = 1'b1;
      for (int k = 1; k <= rows[r].nframes; k++)
        push_frame(t0 + rows[r].spacing * k - 1, rows[r].mask);
      for (int k = 1; k <= rows[r].nframes; k++) begin
        check_at(t0 + rows[r].spacing * k + 1);
        chk("frame_cnt", frame_cnt, k);
        chk("leds", leds, rows[r].exp_leds);
        chk("bank", bank, 0);
      end
      last = t0 + rows[r].spacing * rows[r].nframes - 1;
      wait_cyc(last + 3);
      en = 1'b0;
      wait_idle(400);
      chk_queues();
    end

    // Swap: double request applies once; request in LATCH defers a frame.
    do_reset();
    setup(24'd100, 8'h05, 9'd300, 50);
    t0 = cyc;
    en = 1'b1;
    for (int k = 1; k <= 4; k++) push_frame(t0 + 100 * k - 1, 8'h05);
    ack_q.push_back(t0 + 200);
    ack_q.push_back(t0 + 400);
    pulse_swap(t0 + 130);
    check_at(t0 + 140);
    chk("bank_f1", bank, 0);
    pulse_swap(t0 + 150);
    check_at(t0 + 250);
    chk("bank_f2", bank, 1);
    pulse_swap(t0 + 300);
    check_at(t0 + 350);
    chk("bank_f3", bank, 1);
    check_at(t0 + 450);
    chk("bank_f4", bank, 0);
    chk("frame_cnt_f4", frame_cnt, 4);
    wait_cyc(t0 + 451);
    en = 1'b0;
    wait_idle(400);
    chk_queues();

    // Overrun: ticks landing in WAIT_DONE are dropped and flagged.
    do_reset();
    setup(24'd40, 8'h01, 9'd12, 60);
    t0 = cyc;
    en = 1'b1;
    push_frame(t0 + 39, 8'h01);
    push_frame(t0 + 119, 8'h01);
    ovr_q.push_back(t0 + 79);
    ovr_q.push_back(t0 + 159);
    check_at(t0 + 100);
    chk("ovr_frame_cnt1", frame_cnt, 1);
    chk("ovr_state", dbg_state, WAIT_DONE);
    wait_cyc(t0 + 170);
    en = 1'b0;
    check_at(t0 + 260);
    chk("ovr_frame_cnt2", frame_cnt, 2);
    chk("ovr_idle", dbg_state, IDLE);
    chk_queues();

    // en dropped during ISSUE: all starts still go out, then the timer restarts clean.
    do_reset();
    setup(24'd50, 8'hFF, 9'd5, 10);
    t0 = cyc;
    en = 1'b1;
    push_frame(t0 + 49, 8'hFF);
    wait_cyc(t0 + 53);
    en = 1'b0;
    check_at(t0 + 120);
    chk("drop_idle", dbg_state, IDLE);
    chk("drop_frame_cnt", frame_cnt, 1);
    chk("drop_starts_left", exp_q.size(), 0);
    wait_cyc(t0 + 121);
    t1 = cyc;
    en = 1'b1;
    push_frame(t1 + 49, 8'hFF);
    check_at(t1 + 60);
    chk("restart_frame_cnt", frame_cnt, 2);
    wait_cyc(t1 + 61);
    en = 1'b0;
    wait_idle(400);
    chk_queues();

    // frame_period=0 behaves as 1: empty frames every other cycle, each tick in LATCH overruns.
    do_reset();
    setup(24'd0, 8'h00, 9'd3, 0);
    t0 = cyc;
    en = 1'b1;
    for (int k = 1; k <= 9; k++) ovr_q.push_back(t0 + 2 * k);
    wait_cyc(t0 + 20);
    en = 1'b0;
    check_at(t0 + 22);
    chk("p0_frame_cnt", frame_cnt, 10);
    chk("p0_idle", dbg_state, IDLE);
    chk_queues();

    // Reset in WAIT_DONE clears bank and the pending swap.
    do_reset();
    setup(24'd100, 8'h01, 9'd77, 60);
    t0 = cyc;
    en = 1'b1;
    push_frame(t0 + 99, 8'h01);
    ack_q.push_back(t0 + 100);
    pulse_swap(t0 + 10);
    pulse_swap(t0 + 110);
    check_at(t0 + 150);
    chk("pre_rst_bank", bank, 1);
    chk("pre_rst_leds", leds, 77);
    chk("pre_rst_state", dbg_state, WAIT_DONE);
    do_reset();
    wait_cyc(cyc + 2);
    t1 = cyc;
    en = 1'b1;
    push_frame(t1 + 99, 8'h01);
    check_at(t1 + 150);
    chk("post_rst_bank", bank, 0);
    chk("post_rst_frame_cnt", frame_cnt, 1);
    wait_cyc(t1 + 151);
    en = 1'b0;
    wait_idle(400);
    chk_queues();

    wait_cyc(cyc + 5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
